// File: rtl/park_transform.sv
// Park transform (alpha/beta -> d/q) using one shared signed multiplier sequenced by an FSM.
// Optional macro PARK_CLARKE_EN adds a Clarke stage (phase currents ia/ib -> alpha/beta) ahead of Park.
module park_transform #(
    parameter int DW   = 16,
    parameter int TW   = 16,
    parameter int FRAC = 14
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [TW-1:0] sin_th,
    input  logic signed [TW-1:0] cos_th,
    input  logic signed [DW-1:0] i_alpha,
    input  logic signed [DW-1:0] i_beta,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] i_d,
    output logic signed [DW-1:0] i_q
);
    localparam int PW = DW + TW;
    localparam int AW = DW + TW + 1;
`ifdef PARK_CLARKE_EN
    // Multiplier x operand widened to carry ia + 2*ib without overflow.
    localparam int XW = DW + 2;
`else
    localparam int XW = DW;
`endif
    localparam int MW = XW + TW;
    localparam int SW = MW + 1;

    localparam logic signed [SW-1:0] HALF = SW'(2**(FRAC-1));
    localparam logic signed [SW-1:0] MAXV = SW'(2**(DW-1) - 1);
    localparam logic signed [SW-1:0] MINV = -SW'(2**(DW-1));

`ifdef PARK_CLARKE_EN
    typedef enum logic [2:0] {S_IDLE, S_C0, S_M0, S_M1, S_M2, S_M3, S_OUT} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_M0, S_M1, S_M2, S_M3, S_OUT} state_t;
`endif

    state_t                 state_reg;
    logic signed [DW-1:0]   a_reg, b_reg;
    logic signed [TW-1:0]   sin_reg, cos_reg;
    logic signed [AW-1:0]   acc_reg;
    logic signed [DW-1:0]   id_res_reg;
    logic                   in_ready_reg, out_valid_reg;
    logic signed [DW-1:0]   i_d_reg, i_q_reg;

    logic signed [XW-1:0]   a_x, b_x, mul_x;
    logic signed [TW-1:0]   mul_y;
    logic signed [MW-1:0]   mul_p;
    logic signed [PW-1:0]   prod;
    logic signed [AW-1:0]   sum_next;

    // Round half up, then clamp to the output range.
    function automatic logic signed [DW-1:0] rnd_sat(input logic signed [SW-1:0] v);
        logic signed [SW-1:0] r;
        r = (v + HALF) >>> FRAC;
        if (r > MAXV)
            return MAXV[DW-1:0];
        else if (r < MINV)
            return MINV[DW-1:0];
        else
            return r[DW-1:0];
    endfunction

    assign a_x = XW'(a_reg);
    assign b_x = XW'(b_reg);

    always_comb begin
        mul_x = a_x;
        mul_y = cos_reg;
        case (state_reg)
            S_M1:    begin mul_x = b_x; mul_y = sin_reg; end
            S_M2:    begin mul_x = b_x; mul_y = cos_reg; end
            S_M3:    begin mul_x = a_x; mul_y = sin_reg; end
`ifdef PARK_CLARKE_EN
            S_C0:    begin mul_x = a_x + (b_x <<< 1); mul_y = TW'(9459); end
`endif
            default: begin mul_x = a_x; mul_y = cos_reg; end
        endcase
    end

    assign mul_p    = MW'(mul_x) * MW'(mul_y);
    assign prod     = PW'(mul_p);
    assign sum_next = (state_reg == S_M3) ? (acc_reg - AW'(prod)) : (acc_reg + AW'(prod));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            a_reg         <= '0;
            b_reg         <= '0;
            sin_reg       <= '0;
            cos_reg       <= '0;
            acc_reg       <= '0;
            id_res_reg    <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            i_d_reg       <= '0;
            i_q_reg       <= '0;
        end else begin
            case (state_reg)
                S_IDLE: if (in_valid) begin
                    a_reg        <= i_alpha;
                    b_reg        <= i_beta;
                    sin_reg      <= sin_th;
                    cos_reg      <= cos_th;
                    in_ready_reg <= 1'b0;
`ifdef PARK_CLARKE_EN
                    state_reg    <= S_C0;
`else
                    state_reg    <= S_M0;
`endif
                end
`ifdef PARK_CLARKE_EN
                S_C0: begin
                    b_reg     <= rnd_sat(SW'(mul_p));
                    state_reg <= S_M0;
                end
`endif
                S_M0: begin
                    acc_reg   <= AW'(prod);
                    state_reg <= S_M1;
                end
                S_M1: begin
                    id_res_reg <= rnd_sat(SW'(sum_next));
                    state_reg  <= S_M2;
                end
                S_M2: begin
                    acc_reg   <= AW'(prod);
                    state_reg <= S_M3;
                end
                S_M3: begin
                    i_d_reg       <= id_res_reg;
                    i_q_reg       <= rnd_sat(SW'(sum_next));
                    out_valid_reg <= 1'b1;
                    state_reg     <= S_OUT;
                end
                S_OUT: if (out_ready) begin
                    out_valid_reg <= 1'b0;
                    in_ready_reg  <= 1'b1;
                    state_reg     <= S_IDLE;
                end
                default: begin
                    state_reg     <= S_IDLE;
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign i_d       = i_d_reg;
    assign i_q       = i_q_reg;
endmodule

// File: tb/tb_park_transform.sv
// Bench for park_transform: cycle-level behavioural model plus directed literal cases.
// Honours PARK_CLARKE_EN the same way as the design.
module tb_park_transform;
    localparam int DW   = 16;
    localparam int TW   = 16;
    localparam int FRAC = 14;
`ifdef PARK_CLARKE_EN
    localparam int LAT = 6;
`else
    localparam int LAT = 5;
`endif

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic signed [TW-1:0] sin_th = '0;
    logic signed [TW-1:0] cos_th = '0;
    logic signed [DW-1:0] i_alpha = '0;
    logic signed [DW-1:0] i_beta = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic signed [DW-1:0] i_d;
    logic signed [DW-1:0] i_q;

    int     total = 0;
    int     bad = 0;
    longint cyc = 0;
    int     rdy_mode = 0;  // 0: hold low, 1: hold high, 2: random
    int     txn = 0;

    park_transform #(.DW(DW), .TW(TW), .FRAC(FRAC)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .sin_th(sin_th), .cos_th(cos_th),
        .i_alpha(i_alpha), .i_beta(i_beta),
        .out_valid(out_valid), .out_ready(out_ready),
        .i_d(i_d), .i_q(i_q)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic longint rs(input longint v);
        longint r;
        r = (v + (longint'(1) << (FRAC - 1))) >>> FRAC;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return r;
    endfunction

    // Reference result from the transform equations.
    task automatic model(input longint a, input longint b, input longint s, input longint c,
                         output longint ed, output longint eq);
        longint al, be;
        al = a;
        be = b;
`ifdef PARK_CLARKE_EN
        be = rs((a + 2 * b) * 9459);
`endif
        ed = rs(al * c + be * s);
        eq = rs(be * c - al * s);
    endtask

    // Per-cycle compare against the model; model state advances for the upcoming edge.
    initial begin
        bit     busy = 0;
        bit     exp_ov = 0;
        longint acc_edge = 0;
        longint pend_d = 0, pend_q = 0, shown_d = 0, shown_q = 0;
        forever begin
            @(negedge clk);
            if (cyc > 0) begin
                if (busy && cyc == acc_edge + LAT - 1) begin
                    shown_d = pend_d;
                    shown_q = pend_q;
                end
                exp_ov = busy && (cyc >= acc_edge + LAT - 1);
                check("in_ready", longint'(in_ready), longint'(!busy));
                check("out_valid", longint'(out_valid), longint'(exp_ov));
                check("i_d", longint'(i_d), shown_d);
                check("i_q", longint'(i_q), shown_q);
            end
            if (rst) begin
                busy = 0; exp_ov = 0; shown_d = 0; shown_q = 0;
            end else if (!busy && in_valid) begin
                busy = 1;
                acc_edge = cyc + 1;
                model(longint'(i_alpha), longint'(i_beta), longint'(sin_th), longint'(cos_th),
                      pend_d, pend_q);
            end else if (exp_ov && out_ready) begin
                busy = 0;
                txn++;
                $display("txn %0d: i_d=%0d i_q=%0d", txn, shown_d, shown_q);
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    task automatic send(input int a, input int b, input int s, input int c);
        int n = 0;
        @(posedge clk); #1;
        in_valid = 1'b1;
        i_alpha = DW'(a); i_beta = DW'(b); sin_th = TW'(s); cos_th = TW'(c);
        @(negedge clk);
        while (!in_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) check("accept_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output longint edges);
        int n = 0;
        longint start = cyc;
        @(negedge clk);
        while (!out_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) check("out_timeout", 0, 1);
        edges = cyc + 1 - start;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!(in_ready && !out_valid) && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) check("idle_timeout", 0, 1);
    endtask

    task automatic run_lit(input string name, input int a, input int b, input int s, input int c,
                           input longint ed, input longint eq);
        longint lat;
        rdy_mode = 1;
        send(a, b, s, c);
        wait_out(lat);
        check({name, "_latency"}, lat, LAT);
        check({name, "_i_d"}, longint'(i_d), ed);
        check({name, "_i_q"}, longint'(i_q), eq);
        wait_idle();
    endtask

    initial begin
        longint lat;
        int a, b, s, c;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_in_ready", longint'(in_ready), 1);
        check("reset_out_valid", longint'(out_valid), 0);
        check("reset_i_d", longint'(i_d), 0);
        check("reset_i_q", longint'(i_q), 0);

`ifdef PARK_CLARKE_EN
        run_lit("clarke_basic", 1000, -500, 0, 16384, 1000, 0);
        run_lit("clarke_rot90", 1000, 500, 16384, 0, 1155, -1000);
`else
        run_lit("cos_one", 1000, 500, 0, 16384, 1000, 500);
        run_lit("sin_one", 1000, 500, 16384, 0, 500, -1000);
        run_lit("deg45", 1000, 0, 11585, 11585, 707, -707);
        run_lit("sat_pos", 32767, 32767, 16384, 16384, 32767, 0);
        run_lit("sat_neg", -32768, -32768, 16384, 16384, -32768, 0);
`endif

        // Back-pressure: result held for 10 cycles while new input is offered.
        rdy_mode = 0;
        send(1000, -500, 0, 16384);
        wait_out(lat);
        repeat (10) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            i_alpha = 16'sd123; i_beta = -16'sd77; sin_th = 16'sd4000; cos_th = 16'sd9000;
            @(negedge clk);
            check("hold_in_ready", longint'(in_ready), 0);
        end
        check("hold_out_valid", longint'(out_valid), 1);
        check("hold_i_d", longint'(i_d), 1000);
`ifdef PARK_CLARKE_EN
        check("hold_i_q", longint'(i_q), 0);
`else
        check("hold_i_q", longint'(i_q), -500);
`endif
        @(posedge clk); #1;
        in_valid = 1'b0;
        rdy_mode = 1;
        wait_idle();

        // Reset while the multiply sequence is in progress.
        send(2000, 1500, 3000, 12000);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", longint'(out_valid), 0);
        check("midrst_i_d", longint'(i_d), 0);
        check("midrst_i_q", longint'(i_q), 0);
        check("midrst_in_ready", longint'(in_ready), 1);

        // Randomised traffic with random downstream back-pressure.
        rdy_mode = 2;
        repeat (150) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            a = int'($urandom_range(0, 65535)) - 32768;
            b = int'($urandom_range(0, 65535)) - 32768;
            s = int'($urandom_range(0, 32768)) - 16384;
            c = int'($urandom_range(0, 32768)) - 16384;
            if ($urandom_range(0, 7) == 0) begin
                a = ($urandom_range(0, 1) != 0) ? 32767 : -32768;
                b = a;
                s = 16384;
                c = 16384;
            end
`ifdef PARK_CLARKE_EN
            if ($urandom_range(0, 3) == 0) begin
                a = int'($urandom_range(0, 4000)) - 2000;
                b = int'($urandom_range(0, 4000)) - 2000;
            end
`endif
            send(a, b, s, c);
        end
        rdy_mode = 1;
        wait_idle();
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
